aes256_key_expansion_seq: RTL and testbench
===========================================

# aes256_key_expansion_seq

Iterative AES-256 key schedule. It accepts a 256-bit cipher key and expands it into the 15 round keys (rk0..rk14) consumed by the round pipeline's per-round `i_round_key` inputs. It produces one 128-bit round key per clock using a single SubWord S-box lane, and holds the full schedule in a register bank. It sits directly upstream of the round pipeline in the AES/GCM datapath.

## Interface
- NB_BYTE, 8: bits per byte; only 8 is legal.
- N_BYTES, 16: bytes per round key; only 16 is legal.
- N_ROUNDS, 14: index of the last round key; only 14 is legal (AES-256).
- i_clock  in  1  rising-edge clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_key  in  256  cipher key; bit 255 is the first key byte MSB, per FIPS-197 byte order.
- i_key_valid  in  1  start strobe; sampled only when o_busy=0.
- o_round_keys  out  (N_ROUNDS+1)*128  flat schedule; rk_j occupies bits [128*j+127 : 128*j].
- o_keys_valid  out  1  schedule complete and stable.
- o_busy  out  1  expansion in progress; i_key_valid is ignored while high.
- o_done  out  1  one-cycle pulse on the cycle o_keys_valid rises.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- Reset, asynchronous on i_reset_n=0:
  - state=IDLE; counter=0.
  - Key bank all zero.
  - o_keys_valid=0, o_busy=0, o_done=0.
- IDLE or DONE with i_key_valid=1 (key accept):
  - rk0 <= i_key[255:128], rk1 <= i_key[127:0].
  - rk2..rk14 are retained; they are not cleared.
  - counter <= 2; state <= EXPAND; o_keys_valid <= 0.
- EXPAND: each cycle computes rk_j, with j = counter, from prev2 = rk_{j-2} and prev1 = rk_{j-1}, split into words w0..w3.
  - j even: t = SubWord(RotWord(prev1.w3)) ^ {Rcon[j/2],24'h0}.
  - Rcon[1..7] = 01,02,04,08,10,20,40.
  - j odd: t = SubWord(prev1.w3), with no rotate and no Rcon.
  - n0 = prev2.w0^t; n1 = prev2.w1^n0; n2 = prev2.w2^n1; n3 = prev2.w3^n2.
  - rk_j <= {n0,n1,n2,n3}; counter++.
- Counter wrap: when counter=14 is written, state <= DONE, o_keys_valid <= 1 and o_done <= 1 for one cycle. The counter does not advance past 14.
- DONE holds the schedule indefinitely. A new key accept restarts expansion; o_keys_valid falls on that same edge.
- i_key_valid while EXPAND: dropped, with no queueing and no restart.
- Reset asserted mid-EXPAND: the FSM aborts to the IDLE reset state immediately; no partial o_done is produced.
- SubWord uses 4 combinational S-box byte lookups of the same forward S-box as the cipher rounds. The module contains no other arithmetic; all operations are XOR and byte rewiring.

## Timing
- Edge E0 (accept): rk0 and rk1 become visible after E0; o_busy=1 from E0.
- Edges E1..E13 write rk2..rk14 respectively.
- After E13: o_keys_valid=1, o_done=1 for exactly one cycle, o_busy=0.
- Key-in to schedule-valid latency is 13 cycles after the accept edge; minimum throughput is one key per 14 cycles.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Critical path per cycle: S-box, then Rcon XOR, then a 4-deep XOR chain.

## Configuration
- AES_KEYEXP_ZEROIZE_EN defined:
  - A key accept also clears rk2..rk14 to zero on E0.
  - o_round_keys is driven all-zero whenever o_keys_valid=0, via an output AND mask.
  - Stale or partial key material is never visible downstream.
- AES_KEYEXP_ZEROIZE_EN undefined:
  - No clear and no mask.
  - o_round_keys always reflects the bank contents, including partial schedules during EXPAND.

## Test plan
- FIPS-197 C.3 vector, key 000102..1e1f, checked after o_done:
  - rk1 = 101112131415161718191a1b1c1d1e1f.
  - rk2 = a573c29fa176c498a97fce93a572c09c.
  - rk14 = 24fc79ccbf0979e9371ac23c6d68de36.
  - o_done is high exactly 13 cycles after the accept edge.
- FIPS-197 A.3 key 603deb10..0914dff4: rk14 = fe4890d1e6188d0b046df344706c631e.
- i_key_valid pulsed again at E5 with a different key:
  - The pulse is ignored.
  - The final schedule matches the first key only.
  - Exactly one o_done is produced.
- i_reset_n pulsed low at E7 during expansion:
  - All outputs read 0 asynchronously.
  - The FSM returns to IDLE, and no o_done is produced.
  - A new accept then completes normally.
- Back-to-back keys: a second key is accepted on the cycle after o_done. o_keys_valid drops at that accept edge, and the second schedule is valid 13 cycles later.
- With AES_KEYEXP_ZEROIZE_EN defined:
  - o_round_keys = 0 throughout EXPAND.
  - After the second accept, rk2..rk14 read 0 until they are rewritten.
- Without AES_KEYEXP_ZEROIZE_EN: partial keys from the second expansion are visible during EXPAND.

Source files
------------

// File: rtl/aes256_key_expansion_seq.sv
// aes256_key_expansion_seq
// Iterative AES-256 key schedule. One 128-bit round key is produced per clock
// through a single 4-byte SubWord lane. The full schedule rk0..rk14 is held in
// a register bank and exposed as a flat bus.
//
// Optional feature macro: AES_KEYEXP_ZEROIZE_EN
//   defined   : a key accept clears rk2..rk14, and the output bus is masked to
//               zero whenever o_keys_valid is low.
//   undefined : no clear and no mask. The bus always mirrors the bank,
//               including partial schedules during expansion.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no schedule computed since reset; waiting for i_key_valid
// EXPAND | writing rk[counter] each cycle, counter = 2..14
// DONE   | schedule complete and stable; a new i_key_valid restarts
module aes256_key_expansion_seq #(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 14
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset_n,
  input  logic [2*NB_BYTE*N_BYTES-1:0]          i_key,
  input  logic                                  i_key_valid,
  output logic [(N_ROUNDS+1)*NB_BYTE*N_BYTES-1:0] o_round_keys,
  output logic                                  o_keys_valid,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int KW = NB_BYTE * N_BYTES;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] LAST_IDX  = 4'(N_ROUNDS);
  localparam logic [3:0] FIRST_IDX = 4'd2;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset (255-a)*8, i.e. {~a, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TABLE[{~a, 3'b000} +: 8];
  endfunction

  logic [1:0]    state;
  logic [3:0]    counter;
  logic          keys_valid;
  logic          busy;
  logic          done;
  logic [KW-1:0] rk [N_ROUNDS+1];

  logic          accept;
  logic [3:0]    idx_m1;
  logic [3:0]    idx_m2;
  logic [KW-1:0] prev1;
  logic [KW-1:0] prev2;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [7:0]    rcon;
  logic [31:0]   t_word;
  logic [31:0]   n0, n1, n2, n3;
  logic [KW-1:0] next_key;
  logic [KW-1:0] out_mask;

  assign accept = i_key_valid && ((state == ST_IDLE) || (state == ST_DONE));
  assign idx_m1 = counter - 4'd1;
  assign idx_m2 = counter - 4'd2;

  // Rcon for even key indices; j/2 selects the constant.
  always_comb begin
    rcon = 8'h00;
    case (counter[3:1])
      3'd1: rcon = 8'h01;
      3'd2: rcon = 8'h02;
      3'd3: rcon = 8'h04;
      3'd4: rcon = 8'h08;
      3'd5: rcon = 8'h10;
      3'd6: rcon = 8'h20;
      3'd7: rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  // One schedule step: rk[j] from rk[j-2] and rk[j-1]; odd j skips RotWord/Rcon.
  always_comb begin
    prev1   = rk[idx_m1];
    prev2   = rk[idx_m2];
    sub_in  = counter[0] ? prev1[31:0] : {prev1[23:0], prev1[31:24]};
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
               sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    t_word  = counter[0] ? sub_out : (sub_out ^ {rcon, 24'h000000});
    n0      = prev2[127:96] ^ t_word;
    n1      = prev2[95:64]  ^ n0;
    n2      = prev2[63:32]  ^ n1;
    n3      = prev2[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Sequencer: accept in IDLE/DONE, step counter through EXPAND, flag completion.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      counter    <= 4'd0;
      keys_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_key_valid) begin
            state      <= ST_EXPAND;
            counter    <= FIRST_IDX;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_EXPAND: begin
          if (counter == LAST_IDX) begin
            state      <= ST_DONE;
            keys_valid <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= 4'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Key bank: cipher key halves on accept, one computed key per EXPAND cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int j = 0; j <= N_ROUNDS; j++) begin
        rk[j] <= '0;
      end
    end else if (accept) begin
      rk[0] <= i_key[2*KW-1:KW];
      rk[1] <= i_key[KW-1:0];
`ifdef AES_KEYEXP_ZEROIZE_EN
      for (int j = 2; j <= N_ROUNDS; j++) begin
        rk[j] <= '0;
      end
`endif
    end else if (state == ST_EXPAND) begin
      rk[counter] <= next_key;
    end
  end

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign out_mask = {KW{keys_valid}};
`else
  assign out_mask = {KW{1'b1}};
`endif

  for (genvar g = 0; g <= N_ROUNDS; g++) begin : g_out
    assign o_round_keys[KW*g +: KW] = rk[g] & out_mask;
  end

  assign o_keys_valid = keys_valid;
  assign o_busy       = busy;
  assign o_done       = done;

endmodule

// File: tb/tb_aes256_key_expansion_seq.sv
// Directed bench for aes256_key_expansion_seq using FIPS-197 key vectors.
module tb_aes256_key_expansion_seq;

  logic             i_clock = 1'b0;
  logic             i_reset_n;
  logic [255:0]     i_key;
  logic             i_key_valid;
  logic [15*128-1:0] o_round_keys;
  logic             o_keys_valid;
  logic             o_busy;
  logic             o_done;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes256_key_expansion_seq dut (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_key        (i_key),
    .i_key_valid  (i_key_valid),
    .o_round_keys (o_round_keys),
    .o_keys_valid (o_keys_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [127:0] rk(input int j);
    return o_round_keys[128*j +: 128];
  endfunction

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  // Present a key for exactly one rising edge (E0); returns after E0.
  task automatic start_key(input logic [255:0] key);
    i_key       = key;
    i_key_valid = 1'b1;
    step();
    i_key_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n   = 1'b0;
    i_key_valid = 1'b0;
    i_key       = '0;
    repeat (2) step();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_keys_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_keys_valid); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (|o_round_keys !== 1'b0) begin failures++; $display("FAIL reset_keys nonzero got=%b exp=0", |o_round_keys); end
    i_reset_n = 1'b1;
    repeat (2) step();
    checks++; if ({o_busy, o_keys_valid, o_done} !== 3'b000) begin failures++; $display("FAIL idle_flags got=%b exp=000", {o_busy, o_keys_valid, o_done}); end
  endtask

  task automatic test_fips_c3();
    int early_flags;
    early_flags = 0;
    start_key(KEY_C3);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL c3_busy_after_e0 got=%b exp=1", o_busy); end
`ifdef AES_KEYEXP_ZEROIZE_EN
    checks++; if (|o_round_keys !== 1'b0) begin failures++; $display("FAIL c3_mask_after_e0 got=%b exp=0", |o_round_keys); end
`else
    checks++; if (rk(0) !== C3_RK0) begin failures++; $display("FAIL c3_rk0_after_e0 got=%h exp=%h", rk(0), C3_RK0); end
    checks++; if (rk(1) !== C3_RK1) begin failures++; $display("FAIL c3_rk1_after_e0 got=%h exp=%h", rk(1), C3_RK1); end
`endif
    for (int k = 1; k <= 12; k++) begin
      step();
      if (o_done !== 1'b0 || o_keys_valid !== 1'b0 || o_busy !== 1'b1) early_flags++;
    end
    checks++; if (early_flags != 0) begin failures++; $display("FAIL c3_flags_during_expand bad_cycles=%0d exp=0", early_flags); end
    step();
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL c3_done_at_e13 got=%b exp=1", o_done); end
    checks++; if (o_keys_valid !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL c3_valid_busy_at_e13 got=%b%b exp=10", o_keys_valid, o_busy); end
    checks++; if (rk(1) !== C3_RK1) begin failures++; $display("FAIL c3_rk1 got=%h exp=%h", rk(1), C3_RK1); end
    checks++; if (rk(2) !== C3_RK2) begin failures++; $display("FAIL c3_rk2 got=%h exp=%h", rk(2), C3_RK2); end
    checks++; if (rk(14) !== C3_RK14) begin failures++; $display("FAIL c3_rk14 got=%h exp=%h", rk(14), C3_RK14); end
    step();
    checks++; if (o_done !== 1'b0 || o_keys_valid !== 1'b1) begin failures++; $display("FAIL c3_done_pulse_width done=%b valid=%b exp done=0 valid=1", o_done, o_keys_valid); end
    repeat (3) step();
    checks++; if (rk(14) !== C3_RK14 || o_keys_valid !== 1'b1) begin failures++; $display("FAIL c3_hold got=%h exp=%h", rk(14), C3_RK14); end
  endtask

  task automatic test_fips_a3();
    int first;
    first = -1;
    start_key(KEY_A3);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (o_done === 1'b1 && first < 0) first = k;
    end
    checks++; if (first != 13) begin failures++; $display("FAIL a3_done_cycle got=%0d exp=13", first); end
    checks++; if (rk(0) !== A3_RK0) begin failures++; $display("FAIL a3_rk0 got=%h exp=%h", rk(0), A3_RK0); end
    checks++; if (rk(14) !== A3_RK14) begin failures++; $display("FAIL a3_rk14 got=%h exp=%h", rk(14), A3_RK14); end
  endtask

  task automatic test_ignore_valid();
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    start_key(KEY_C3);
    repeat (4) step();
    i_key       = KEY_A3;
    i_key_valid = 1'b1;
    step();
    i_key_valid = 1'b0;
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL ign_busy_after_e5 got=%b exp=1", o_busy); end
    for (int k = 6; k <= 24; k++) begin
      step();
      if (o_done === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", pulses); end
    checks++; if (first != 13) begin failures++; $display("FAIL ign_done_cycle got=%0d exp=13", first); end
    checks++; if (rk(0) !== C3_RK0) begin failures++; $display("FAIL ign_rk0 got=%h exp=%h", rk(0), C3_RK0); end
    checks++; if (rk(14) !== C3_RK14) begin failures++; $display("FAIL ign_rk14 got=%h exp=%h", rk(14), C3_RK14); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    start_key(KEY_A3);
    repeat (7) step();
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL rst_busy_before got=%b exp=1", o_busy); end
    i_reset_n = 1'b0;
    #1;
    checks++; if ({o_busy, o_keys_valid, o_done} !== 3'b000) begin failures++; $display("FAIL rst_async_flags got=%b exp=000", {o_busy, o_keys_valid, o_done}); end
    checks++; if (|o_round_keys !== 1'b0) begin failures++; $display("FAIL rst_async_keys nonzero got=%b exp=0", |o_round_keys); end
    @(negedge i_clock);
    i_reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (o_done === 1'b1 || o_busy === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rst_no_done_after_abort got=%0d exp=0", pulses); end
    start_key(KEY_C3);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (o_done === 1'b1 && first < 0) first = k;
    end
    checks++; if (first != 13) begin failures++; $display("FAIL rst_restart_done_cycle got=%0d exp=13", first); end
    checks++; if (rk(14) !== C3_RK14) begin failures++; $display("FAIL rst_restart_rk14 got=%h exp=%h", rk(14), C3_RK14); end
  endtask

  task automatic test_back_to_back();
    int first;
    int leaks;
    first = -1;
    leaks = 0;
    start_key(KEY_C3);
    repeat (13) step();
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b exp=1", o_done); end
    start_key(KEY_A3);
    checks++; if ({o_keys_valid, o_busy, o_done} !== 3'b010) begin failures++; $display("FAIL b2b_accept_flags got=%b exp=010", {o_keys_valid, o_busy, o_done}); end
`ifdef AES_KEYEXP_ZEROIZE_EN
    checks++; if (|o_round_keys !== 1'b0) begin failures++; $display("FAIL b2b_mask_after_e0 got=%b exp=0", |o_round_keys); end
`else
    checks++; if (rk(0) !== A3_RK0) begin failures++; $display("FAIL b2b_partial_rk0 got=%h exp=%h", rk(0), A3_RK0); end
    checks++; if (rk(14) !== C3_RK14) begin failures++; $display("FAIL b2b_retained_rk14 got=%h exp=%h", rk(14), C3_RK14); end
`endif
    step();
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (|o_round_keys !== 1'b0) leaks++;
`else
    checks++; if (rk(2) === C3_RK2) begin failures++; $display("FAIL b2b_partial_rk2 got=%h exp=new_value", rk(2)); end
    checks++; if (rk(14) !== C3_RK14) begin failures++; $display("FAIL b2b_stale_rk14 got=%h exp=%h", rk(14), C3_RK14); end
`endif
    if (o_done === 1'b1) first = 1;
    for (int k = 2; k <= 13; k++) begin
      step();
`ifdef AES_KEYEXP_ZEROIZE_EN
      if (k < 13 && |o_round_keys !== 1'b0) leaks++;
`endif
      if (o_done === 1'b1 && first < 0) first = k;
    end
`ifdef AES_KEYEXP_ZEROIZE_EN
    checks++; if (leaks != 0) begin failures++; $display("FAIL b2b_mask_during_expand cycles=%0d exp=0", leaks); end
`endif
    checks++; if (first != 13) begin failures++; $display("FAIL b2b_second_done_cycle got=%0d exp=13", first); end
    checks++; if (rk(14) !== A3_RK14 || o_keys_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_rk14 got=%h exp=%h", rk(14), A3_RK14); end
  endtask

  initial begin
    test_reset();
    test_fips_c3();
    test_fips_a3();
    test_ignore_valid();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
